// File: rtl/minibyte_ctrl_if.sv
// rtl/minibyte_ctrl_if.sv - control/datapath signal bundle for the minibyte control unit
interface minibyte_ctrl_if;
   logic [7:0] data_in;
   logic       flag_z_in;
   logic       flag_n_in;
   logic       set_a_out;
   logic       set_m_out;
   logic       set_pc_out;
   logic       inc_pc_out;
   logic       addr_mux_out;
   logic [2:0] alu_op_out;
   logic       we_out;
   logic       halt_out;

   modport master (
      input  data_in, flag_z_in, flag_n_in,
      output set_a_out, set_m_out, set_pc_out, inc_pc_out,
             addr_mux_out, alu_op_out, we_out, halt_out
   );

   modport slave (
      output data_in, flag_z_in, flag_n_in,
      input  set_a_out, set_m_out, set_pc_out, inc_pc_out,
             addr_mux_out, alu_op_out, we_out, halt_out
   );
endinterface

// File: rtl/minibyte_ctrl.sv
// rtl/minibyte_ctrl.sv - multi-cycle fetch/decode/execute control unit for the minibyte CPU
module minibyte_ctrl #(
   parameter bit ILLEGAL_HALTS = 1'b0
) (
   input  logic            clk_in,
   input  logic            rst_in,
   minibyte_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_OPERAND = 2'd1,
      S_MEM     = 2'd2,
      S_HALT    = 2'd3
   } state_t;

   localparam logic [2:0] ALU_PASS_B = 3'd0;
   localparam logic [2:0] ALU_PASS_A = 3'd1;
   localparam logic [2:0] ALU_ADD    = 3'd2;

   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_LDA_I = 8'h01;
   localparam logic [7:0] OP_LDM_I = 8'h02;
   localparam logic [7:0] OP_LDA_M = 8'h03;
   localparam logic [7:0] OP_STA_M = 8'h04;
   localparam logic [7:0] OP_ADD_I = 8'h05;
   localparam logic [7:0] OP_XOR_I = 8'h09;
   localparam logic [7:0] OP_JMP   = 8'h0A;
   localparam logic [7:0] OP_JZ    = 8'h0B;
   localparam logic [7:0] OP_JN    = 8'h0C;
   localparam logic [7:0] OP_ADD_M = 8'h0D;
   localparam logic [7:0] OP_HLT   = 8'hFF;

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_ir;
   logic       r_z;
   logic       r_n;

   logic       w_set_a;
   logic       w_set_m;
   logic       w_set_pc;
   logic       w_inc_pc;
   logic       w_addr_mux;
   logic [2:0] w_alu_op;
   logic       w_we;
   logic       w_halt;
   logic       w_defined;
   logic       w_is_mem_op;

   assign w_defined   = (bus.data_in <= OP_ADD_M) || (bus.data_in == OP_HLT);
   assign w_is_mem_op = (bus.data_in == OP_LDA_M) || (bus.data_in == OP_STA_M) ||
                        (bus.data_in == OP_ADD_M);

   // Flags only move with an A load, so branches see results of earlier instructions.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_state <= S_FETCH;
         r_ir    <= 8'h00;
         r_z     <= 1'b0;
         r_n     <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_FETCH) begin
            r_ir <= bus.data_in;
         end
         if (w_set_a) begin
            r_z <= bus.flag_z_in;
            r_n <= bus.flag_n_in;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH: begin
            if (bus.data_in == OP_NOP) begin
               w_next = S_FETCH;
            end else if (bus.data_in == OP_HLT) begin
               w_next = S_HALT;
            end else if (!w_defined) begin
               w_next = ILLEGAL_HALTS ? S_HALT : S_FETCH;
            end else if (w_is_mem_op) begin
               w_next = S_MEM;
            end else begin
               w_next = S_OPERAND;
            end
         end
         S_OPERAND: w_next = S_FETCH;
         S_MEM:     w_next = S_FETCH;
         S_HALT:    w_next = S_HALT;
         default:   w_next = S_FETCH;
      endcase
   end

   always_comb begin
      w_set_a    = 1'b0;
      w_set_m    = 1'b0;
      w_set_pc   = 1'b0;
      w_inc_pc   = 1'b0;
      w_addr_mux = 1'b0;
      w_alu_op   = ALU_PASS_B;
      w_we       = 1'b0;
      w_halt     = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_inc_pc = 1'b1;
         end
         S_OPERAND: begin
            if (r_ir == OP_LDA_I) begin
               w_set_a  = 1'b1;
               w_inc_pc = 1'b1;
            end else if (r_ir == OP_LDM_I) begin
               w_set_m  = 1'b1;
               w_inc_pc = 1'b1;
            end else if ((r_ir >= OP_ADD_I) && (r_ir <= OP_XOR_I)) begin
               // Opcodes 05..09 map onto ALU codes 2..6 in order.
               w_alu_op = r_ir[2:0] - 3'd3;
               w_set_a  = 1'b1;
               w_inc_pc = 1'b1;
            end else if (r_ir == OP_JMP) begin
               w_set_pc = 1'b1;
            end else if (r_ir == OP_JZ) begin
               w_set_pc = r_z;
               w_inc_pc = !r_z;
            end else if (r_ir == OP_JN) begin
               w_set_pc = r_n;
               w_inc_pc = !r_n;
            end else begin
               w_inc_pc = 1'b1;
            end
         end
         S_MEM: begin
            w_addr_mux = 1'b1;
            if (r_ir == OP_LDA_M) begin
               w_set_a = 1'b1;
            end else if (r_ir == OP_ADD_M) begin
               w_alu_op = ALU_ADD;
               w_set_a  = 1'b1;
            end else if (r_ir == OP_STA_M) begin
               w_alu_op = ALU_PASS_A;
               w_we     = 1'b1;
            end
         end
         S_HALT: begin
            w_halt = 1'b1;
         end
         default: begin
            w_halt = 1'b0;
         end
      endcase
   end

   assign bus.set_a_out    = rst_in & w_set_a;
   assign bus.set_m_out    = rst_in & w_set_m;
   assign bus.set_pc_out   = rst_in & w_set_pc;
   assign bus.inc_pc_out   = rst_in & w_inc_pc;
   assign bus.addr_mux_out = rst_in & w_addr_mux;
   assign bus.alu_op_out   = rst_in ? w_alu_op : 3'd0;
   assign bus.we_out       = rst_in & w_we;
   assign bus.halt_out     = rst_in & w_halt;

endmodule
